hazard_ctrl: RTL and testbench

Pipeline hazard controller for the five-stage RISC-V core; it drives the ID/EX pipeline register's `pc_stop` hold and inserts bubbles and flushes. It detects load-use hazards, sequences multi-cycle EX operations (mul/div) and flushes IF/ID and ID/EX on taken branches. It sits beside the decode stage, observes ID and EX fields, and fans out stall and flush controls to the PC, IF/ID and ID/EX registers. A saturating stall-cycle counter is exposed for performance debug.

---
 rtl/hazard_pkg.sv | 16 +
 rtl/hazard_ctrl_if.sv | 40 ++++
 rtl/sat_counter.sv | 34 +++
 rtl/hazard_ctrl.sv | 116 +++++++++++
 tb/tb_hazard_ctrl.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   state_e   : controller FSM states
//   NopCtrl   : control word loaded into ID/EX for a bubble
//   RegAddrW  : architectural register-address width
package hazard_pkg;

    typedef enum logic [1:0] {
        StRun    = 2'd0,
        StMcWait = 2'd1,
        StFlush  = 2'd2
    } state_e;

    localparam logic [7:0]  NopCtrl  = 8'h00;
    localparam int unsigned RegAddrW = 5;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the decode/execute stages and the hazard controller.
//   master : pipeline side; drives ID/EX fields, receives stall/flush controls
//   slave  : hazard controller
// Fields:
//   id_rs1_addr/id_rs2_addr/id_uses_rs2 : source operands of the ID instruction
//   ex_reg_addr/ex_mem_read             : destination and load flag of the EX instruction
//   ex_branch_taken/ex_mc_start         : EX control events
//   pc_stop/if_id_flush/id_ex_bubble    : pipeline controls
//   busy/stall_cnt                      : status and performance counter
interface hazard_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    import hazard_pkg::*;

    logic [RegAddrW-1:0] id_rs1_addr;
    logic [RegAddrW-1:0] id_rs2_addr;
    logic                id_uses_rs2;
    logic [RegAddrW-1:0] ex_reg_addr;
    logic                ex_mem_read;
    logic                ex_branch_taken;
    logic                ex_mc_start;
    logic                pc_stop;
    logic                if_id_flush;
    logic                id_ex_bubble;
    logic                busy;
    logic [CNT_W-1:0]    stall_cnt;

    modport master (
        output id_rs1_addr, id_rs2_addr, id_uses_rs2, ex_reg_addr, ex_mem_read,
               ex_branch_taken, ex_mc_start,
        input  pc_stop, if_id_flush, id_ex_bubble, busy, stall_cnt
    );

    modport slave (
        input  id_rs1_addr, id_rs2_addr, id_uses_rs2, ex_reg_addr, ex_mem_read,
               ex_branch_taken, ex_mc_start,
        output pc_stop, if_id_flush, id_ex_bubble, busy, stall_cnt
    );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter.
//   clk   : clock
//   rst_n : asynchronous active-low reset, clears the count
//   inc   : increment on the next rising edge
//   count : current value; sticks at all-ones
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, multi-cycle EX sequencing and
// taken-branch flush for the five-stage core.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : hazard_ctrl_if slave (ID/EX fields in, pipeline controls out)
// Parameters:
//   FLUSH_CYCLES : cycles of flush+bubble after a taken branch (1..7)
//   MC_LAT       : total EX occupancy of a multi-cycle op (2..15)
//   CNT_W        : width of the stall-cycle counter
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned MC_LAT       = 4,
    parameter int unsigned CNT_W        = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    hazard_ctrl_if.slave  bus
);

    // The event cycle itself is spent in RUN, so the wait states cover the rest.
    // pc_stop spans MC_LAT-1 cycles: one in RUN plus MC_LAT-2 in MC_WAIT.
    localparam logic [3:0] FlushCntInit = 4'(FLUSH_CYCLES > 1 ? FLUSH_CYCLES - 2 : 0);
    localparam logic [3:0] McCntInit    = 4'(MC_LAT > 2 ? MC_LAT - 3 : 0);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       load_use;
    logic       stop_raw, flush_raw, bubble_raw, busy_raw;
    logic       stop_gated;

    assign load_use = bus.ex_mem_read && (bus.ex_reg_addr != '0) &&
                      ((bus.ex_reg_addr == bus.id_rs1_addr) ||
                       (bus.id_uses_rs2 && (bus.ex_reg_addr == bus.id_rs2_addr)));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        stop_raw   = 1'b0;
        flush_raw  = 1'b0;
        bubble_raw = 1'b0;
        busy_raw   = 1'b0;
        unique case (state_q)
            StRun: begin
                if (bus.ex_branch_taken) begin
                    flush_raw  = 1'b1;
                    bubble_raw = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_d = StFlush;
                        cnt_d   = FlushCntInit;
                    end
                end else if (bus.ex_mc_start) begin
                    stop_raw = 1'b1;
                    if (MC_LAT > 2) begin
                        state_d = StMcWait;
                        cnt_d   = McCntInit;
                    end
                end else if (load_use) begin
                    // ID/EX takes the bubble even though pc_stop holds it.
                    stop_raw   = 1'b1;
                    bubble_raw = 1'b1;
                end
            end
            StMcWait: begin
                stop_raw = 1'b1;
                busy_raw = 1'b1;
                if (cnt_q == '0) begin
                    state_d = StRun;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StFlush: begin
                flush_raw  = 1'b1;
                bubble_raw = 1'b1;
                busy_raw   = 1'b1;
                if (cnt_q == '0) begin
                    state_d = StRun;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = StRun;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StRun;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // RUN outputs follow the inputs, so reset must mask them explicitly.
    assign stop_gated       = rst_n & stop_raw;
    assign bus.pc_stop      = stop_gated;
    assign bus.if_id_flush  = rst_n & flush_raw;
    assign bus.id_ex_bubble = rst_n & bubble_raw;
    assign bus.busy         = rst_n & busy_raw;

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stop_gated),
        .count (bus.stall_cnt)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;
    import hazard_pkg::*;

    localparam int unsigned FlushCycles = 2;
    localparam int unsigned McLat       = 4;
    localparam int unsigned CntW        = 4;
    localparam int          CntMax      = (1 << CntW) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    hazard_ctrl_if #(.CNT_W(CntW)) bif ();

    hazard_ctrl #(
        .FLUSH_CYCLES (FlushCycles),
        .MC_LAT       (McLat),
        .CNT_W        (CntW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    typedef struct packed {
        logic            pc_stop;
        logic            flush;
        logic            bubble;
        logic            busy;
        logic [CntW-1:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: cycles still owed to an in-progress op, plus total stalls.
    int mc_left = 0;
    int fl_left = 0;
    int stalls  = 0;

    // Drive one cycle of inputs, predict that cycle's outputs, queue the prediction.
    task automatic step(input bit rst, input bit br, input bit mc, input bit mr,
                        input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input bit u2);
        exp_t e;
        bit   lu;
        @(posedge clk);
        #1;
        rst_n               = ~rst;
        bif.ex_branch_taken = br;
        bif.ex_mc_start     = mc;
        bif.ex_mem_read     = mr;
        bif.ex_reg_addr     = rd;
        bif.id_rs1_addr     = rs1;
        bif.id_rs2_addr     = rs2;
        bif.id_uses_rs2     = u2;
        e  = '0;
        lu = mr && (rd != 0) && ((rd == rs1) || (u2 && (rd == rs2)));
        if (rst) begin
            mc_left = 0;
            fl_left = 0;
            stalls  = 0;
        end else begin
            e.cnt = CntW'(stalls);
            if (fl_left > 0) begin
                e.flush = 1; e.bubble = 1; e.busy = 1;
                fl_left--;
            end else if (mc_left > 0) begin
                e.pc_stop = 1; e.busy = 1;
                mc_left--;
            end else if (br) begin
                e.flush = 1; e.bubble = 1;
                fl_left = FlushCycles - 1;
            end else if (mc) begin
                e.pc_stop = 1;
                mc_left = McLat - 2;
            end else if (lu) begin
                e.pc_stop = 1; e.bubble = 1;
            end
            if (e.pc_stop && stalls < CntMax) stalls++;
        end
        exp_q.push_back(e);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    endtask

    // Monitor: compares each queued prediction mid-cycle.
    initial begin
        exp_t e;
        exp_t got;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = {bif.pc_stop, bif.if_id_flush, bif.id_ex_bubble, bif.busy, bif.stall_cnt};
                checks++;
                if (got !== e) begin
                    errors++;
                    $display("FAIL ctrl t=%0t got stop=%b flush=%b bubble=%b busy=%b cnt=%0d want stop=%b flush=%b bubble=%b busy=%b cnt=%0d",
                             $time, got.pc_stop, got.flush, got.bubble, got.busy, got.cnt,
                             e.pc_stop, e.flush, e.bubble, e.busy, e.cnt);
                end
            end
        end
    end

    initial begin
        bif.ex_branch_taken = 0;
        bif.ex_mc_start     = 0;
        bif.ex_mem_read     = 0;
        bif.ex_reg_addr     = '0;
        bif.id_rs1_addr     = '0;
        bif.id_rs2_addr     = '0;
        bif.id_uses_rs2     = 0;

        // Reset with live events on the inputs: controls must stay low.
        step(1, 1, 1, 1, 5'd5, 5'd5, 5'd0, 0);
        step(1, 0, 1, 1, 5'd5, 5'd5, 5'd0, 0);
        idle();

        // Load-use on rs1, then quiet.
        step(0, 0, 0, 1, 5'd5, 5'd5, 5'd0, 0);
        idle();

        // rd=x0 and unused rs2 must not stall; used rs2 must.
        step(0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 0);
        step(0, 0, 0, 1, 5'd7, 5'd1, 5'd7, 0);
        step(0, 0, 0, 1, 5'd7, 5'd1, 5'd7, 1);
        idle();

        // Multi-cycle op; branch during MC_WAIT is ignored.
        step(0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0);
        step(0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        step(0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        idle();

        // Branch wins over mc and load-use in the same cycle; FLUSH ignores mc.
        step(0, 1, 1, 1, 5'd5, 5'd5, 5'd0, 0);
        step(0, 0, 1, 1, 5'd5, 5'd5, 5'd0, 0);
        idle();

        // Back-to-back: load-use on the first cycle back in RUN.
        step(0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0);
        step(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        step(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        step(0, 0, 0, 1, 5'd3, 5'd3, 5'd0, 0);
        step(0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        step(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        step(0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0);
        idle();
        idle();
        idle();

        // Reset mid-MC_WAIT, then no stall until a new event.
        step(0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0);
        step(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        step(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        idle();
        idle();
        idle();

        // Randomised traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 7) == 0), $urandom_range(0, 1),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)), $urandom_range(0, 1));
        end

        // Saturation: over 15 stall cycles from a clean reset.
        step(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        for (int i = 0; i < 7; i++) begin
            step(0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0);
            idle();
            idle();
        end
        idle();
        idle();

        repeat (3) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
